// File: rtl/rom_chunked_magnitude_adder.sv
// Multi-cycle chunked adder using a {cin,a,b}->{cout,sum} lookup ROM.
// Optional subtract mode via ADDER_SUBTRACT_EN (adds op port).
module rom_chunked_magnitude_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADDER_SUBTRACT_EN
  input  logic           op,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] sum
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int AW     = 2 * CHUNK + 1;
  localparam int DEPTH  = 1 << AW;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of CHUNK");
  end
  if (CHUNK < 1 || CHUNK > 6) begin : g_bad_chunk
    $error("CHUNK must be in 1..6");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic [WIDTH:0]   sum_q, sum_d;

  // Constant contents per address, so this maps to a pure LUT.
  logic [CHUNK:0] rom [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [AW-1:0] ADR = AW'(i);
    assign rom[i] = (CHUNK+1)'(ADR[AW-2:CHUNK])
                  + (CHUNK+1)'(ADR[CHUNK-1:0])
                  + (CHUNK+1)'(ADR[AW-1]);
  end

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   rom_out;

  assign a_sl    = a_q[k_q*CHUNK +: CHUNK];
  assign b_sl    = b_q[k_q*CHUNK +: CHUNK] ^ {CHUNK{op_q}};
  assign rom_out = rom[{carry_q, a_sl, b_sl}];

  logic op_in;
`ifdef ADDER_SUBTRACT_EN
  assign op_in = op;
`else
  assign op_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op_in;
          carry_d = op_in;
          k_d     = '0;
          sum_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[k_q*CHUNK +: CHUNK] = rom_out[CHUNK-1:0];
        carry_d = rom_out[CHUNK];
        k_d     = k_q + 1'b1;
        if (k_q == KLAST) begin
          sum_d[WIDTH] = rom_out[CHUNK];
          k_d          = '0;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_rom_chunked_magnitude_adder.sv
// Self-checking bench for rom_chunked_magnitude_adder (WIDTH=16, CHUNK=4).
// Subtract scenarios are compiled in when ADDER_SUBTRACT_EN is defined.
module tb_rom_chunked_magnitude_adder;

  localparam int W  = 16;
  localparam int NC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   sum;

  int n_chk  = 0;
  int n_fail = 0;

  rom_chunked_magnitude_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
`ifdef ADDER_SUBTRACT_EN
    .op       (op),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: exact wide arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic o);
    logic [W:0] r;
    if (o) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  // Drives one transaction; lat = -1 on timeout. Leaves result unconsumed.
  task automatic start_and_wait(input logic [W-1:0] x,
                                input logic [W-1:0] y,
                                input logic o,
                                output int lat);
    int n;
    in_valid = 1'b1;
    a = x;
    b = y;
    op = o;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    lat = out_valid ? n : -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h0001;
    b = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: ov=%b sum=%h rdy=%b, want 0/0/0",
                 i, out_valid, sum, in_ready);
      end
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b ov=%b sum=%h, want 1/0/0",
               in_ready, out_valid, sum);
    end
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    int lat;
    ta = '{16'h0001, 16'h0002, 16'h0004, 16'hFFFF, 16'hFFFF};
    tb = '{16'h0002, 16'h0004, 16'h0001, 16'h0001, 16'hFFFF};
    for (int i = 0; i < 5; i++) begin
      start_and_wait(ta[i], tb[i], 1'b0, lat);
      n_chk++;
      if (lat !== NC) begin
        n_fail++;
        $display("FAIL add_latency[%0d]: got %0d cycles, want %0d",
                 i, lat, NC);
      end
      n_chk++;
      if (sum !== model(ta[i], tb[i], 1'b0)) begin
        n_fail++;
        $display("FAIL add_sum[%0d]: %h+%h got %h, want %h",
                 i, ta[i], tb[i], sum, model(ta[i], tb[i], 1'b0));
      end
      consume();
    end
  endtask

  task automatic test_random(input logic sub_en);
    logic [W-1:0] x, y;
    logic o;
    int lat;
    for (int i = 0; i < 30; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      o = sub_en ? 1'($urandom) : 1'b0;
      start_and_wait(x, y, o, lat);
      n_chk++;
      if (lat !== NC || sum !== model(x, y, o)) begin
        n_fail++;
        $display("FAIL rand[%0d]: %h op%b %h got %h lat %0d, want %h lat %0d",
                 i, x, o, y, sum, lat, model(x, y, o), NC);
      end
      consume();
    end
  endtask

  task automatic test_idle_ready();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_out_ready[%0d]: ov=%b rdy=%b, want 0/1",
                 i, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y, x2, y2;
    logic [W:0] exp;
    int lat;
    logic ok;
    x = W'($urandom);
    y = W'($urandom);
    x2 = W'($urandom);
    y2 = W'($urandom);
    exp = model(x, y, 1'b0);
    start_and_wait(x, y, 1'b0, lat);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || sum !== exp) ok = 1'b0;
    end
    n_chk++;
    if (!ok || lat !== NC) begin
      n_fail++;
      $display("FAIL backpressure: ov=%b sum=%h lat %0d, want 1 %h lat %0d",
               out_valid, sum, lat, exp, NC);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = x2;
    b = y2;
    op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: ov=%b rdy=%b, want 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: rdy=%b, want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat !== NC || sum !== model(x2, y2, 1'b0)) begin
      n_fail++;
      $display("FAIL b2b_result: sum=%h lat %0d, want %h lat %0d",
               sum, lat, model(x2, y2, 1'b0), NC);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: ov=%b sum=%h rdy=%b, want 0/0/1",
               out_valid, sum, in_ready);
    end
    @(negedge clk);
    start_and_wait(16'h0003, 16'h0004, 1'b0, lat);
    n_chk++;
    if (lat !== NC || sum !== 17'h00007) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: sum=%h lat %0d, want 00007 lat %0d",
               sum, lat, NC);
    end
    consume();
  endtask

`ifdef ADDER_SUBTRACT_EN
  task automatic test_subtract();
    int lat;
    start_and_wait(16'd5, 16'd7, 1'b1, lat);
    n_chk++;
    if (lat !== NC || sum !== 17'h0FFFE) begin
      n_fail++;
      $display("FAIL sub_5_7: sum=%h, want 0fffe", sum);
    end
    consume();
    start_and_wait(16'd7, 16'd5, 1'b1, lat);
    n_chk++;
    if (lat !== NC || sum !== 17'h10002) begin
      n_fail++;
      $display("FAIL sub_7_5: sum=%h, want 10002", sum);
    end
    consume();
    start_and_wait(16'h1234, 16'h1234, 1'b1, lat);
    n_chk++;
    if (sum !== 17'h10000) begin
      n_fail++;
      $display("FAIL sub_equal: sum=%h, want 10000", sum);
    end
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_idle_ready();
    test_back_to_back();
    test_reset_mid();
`ifdef ADDER_SUBTRACT_EN
    test_subtract();
    test_random(1'b1);
`else
    test_random(1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
